// File: rtl/exe_mem_control_if.sv
// Execute-to-Memory pipeline bus: Execute-stage controls in, Memory-stage copies,
// the stall request and the memory access strobe out.
interface exe_mem_control_if;
  logic       en;
  logic       flush;
  logic [2:0] RegWriteE;
  logic [1:0] ResultSrcE;
  logic [1:0] MemWriteE;
  logic [2:0] funct3E;
  logic [2:0] RegWriteM;
  logic [1:0] ResultSrcM;
  logic [1:0] MemWriteM;
  logic [2:0] funct3M;
  logic       stallM;
  logic       mem_req;

  // Capture happens on a rising edge when the block is idle and en is high;
  // stallM holds the upstream stages for the remainder of a multi-cycle access.
  modport slave (
    input  en, flush, RegWriteE, ResultSrcE, MemWriteE, funct3E,
    output RegWriteM, ResultSrcM, MemWriteM, funct3M, stallM, mem_req
  );

  modport master (
    output en, flush, RegWriteE, ResultSrcE, MemWriteE, funct3E,
    input  RegWriteM, ResultSrcM, MemWriteM, funct3M, stallM, mem_req
  );
endinterface

// File: rtl/exe_mem_control.sv
// Execute/Memory pipeline register with a data-memory access sequencer that
// stalls upstream stages for MEM_LATENCY-1 cycles per load or store.
module exe_mem_control #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  exe_mem_control_if.slave    bus,
  output logic                o_dbg_state
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] LP_CNT_LOAD = CNT_WIDTH'(MEM_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] LP_ONE      = CNT_WIDTH'(1);
  localparam bit                   LP_MULTI    = (MEM_LATENCY > 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_next_cnt;
  logic [2:0]           r_regwrite;
  logic [1:0]           r_resultsrc;
  logic [1:0]           r_memwrite;
  logic [2:0]           r_funct3;
  logic                 r_mem_req;
  logic                 w_capture;
  logic                 w_is_mem;
  logic                 w_start;

  // en and flush are only honoured while idle, so an in-flight access is never disturbed.
  assign w_capture = (r_state == IDLE) && bus.en;
  assign w_is_mem  = (bus.MemWriteE != 2'b00) || (bus.ResultSrcE == 2'b01);
  assign w_start   = w_capture && !bus.flush && w_is_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_next_cnt = '0;
        if (w_start && LP_MULTI) begin
          w_next_state = ACCESS;
          w_next_cnt   = LP_CNT_LOAD;
        end
      end
      ACCESS: begin
        // Leaving on cnt==1 (or a defensive 0) keeps the counter from ever wrapping.
        if (r_cnt <= LP_ONE) begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt   = r_cnt - LP_ONE;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regwrite  <= '0;
      r_resultsrc <= '0;
      r_memwrite  <= '0;
      r_funct3    <= '0;
      r_mem_req   <= 1'b0;
    end else begin
      r_mem_req <= w_start;
      if (w_capture) begin
        if (bus.flush) begin
          r_regwrite  <= '0;
          r_resultsrc <= '0;
          r_memwrite  <= '0;
          r_funct3    <= '0;
        end else begin
          r_regwrite  <= bus.RegWriteE;
          r_resultsrc <= bus.ResultSrcE;
          r_memwrite  <= bus.MemWriteE;
          r_funct3    <= bus.funct3E;
        end
      end
    end
  end

  assign bus.RegWriteM  = r_regwrite;
  assign bus.ResultSrcM = r_resultsrc;
  assign bus.MemWriteM  = r_memwrite;
  assign bus.funct3M    = r_funct3;
  assign bus.mem_req    = r_mem_req;
  assign bus.stallM     = (r_state == ACCESS);
  assign o_dbg_state    = (r_state == ACCESS);

endmodule

// File: tb/tb_exe_mem_control.sv
// Directed bench for exe_mem_control: three instances (latency 1, 2, 3) share
// clock, reset and stimulus; each scenario task checks the relevant instance.
module tb_exe_mem_control;
  logic clk;
  logic rst;
  logic dbg1, dbg2, dbg3;
  int   checks;
  int   errors;

  exe_mem_control_if b1 ();
  exe_mem_control_if b2 ();
  exe_mem_control_if b3 ();

  exe_mem_control #(.MEM_LATENCY(1), .CNT_WIDTH(4)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave), .o_dbg_state(dbg1));
  exe_mem_control #(.MEM_LATENCY(2), .CNT_WIDTH(4)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave), .o_dbg_state(dbg2));
  exe_mem_control #(.MEM_LATENCY(3), .CNT_WIDTH(4)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave), .o_dbg_state(dbg3));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // M bundle packed as {RegWriteM, ResultSrcM, MemWriteM, funct3M}
  function automatic logic [9:0] m1();
    return {b1.RegWriteM, b1.ResultSrcM, b1.MemWriteM, b1.funct3M};
  endfunction
  function automatic logic [9:0] m2();
    return {b2.RegWriteM, b2.ResultSrcM, b2.MemWriteM, b2.funct3M};
  endfunction
  function automatic logic [9:0] m3();
    return {b3.RegWriteM, b3.ResultSrcM, b3.MemWriteM, b3.funct3M};
  endfunction

  // driver tasks
  task automatic set_in(input logic en, input logic fl, input logic [2:0] rw,
                        input logic [1:0] rs, input logic [1:0] mw, input logic [2:0] f3);
    b1.en = en; b1.flush = fl; b1.RegWriteE = rw; b1.ResultSrcE = rs; b1.MemWriteE = mw; b1.funct3E = f3;
    b2.en = en; b2.flush = fl; b2.RegWriteE = rw; b2.ResultSrcE = rs; b2.MemWriteE = mw; b2.funct3E = f3;
    b3.en = en; b3.flush = fl; b3.RegWriteE = rw; b3.ResultSrcE = rs; b3.MemWriteE = mw; b3.funct3E = f3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    set_in(1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 3'b000);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    set_in(1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 3'b000);
    rst = 1'b1;
    #1 rst = 1'b0;
    #6;
    checks++; if ({m1(), b1.stallM, b1.mem_req} !== 12'h000) begin errors++; $display("FAIL reset_dut1 got=%h exp=000", {m1(), b1.stallM, b1.mem_req}); end
    checks++; if ({m2(), b2.stallM, b2.mem_req} !== 12'h000) begin errors++; $display("FAIL reset_dut2 got=%h exp=000", {m2(), b2.stallM, b2.mem_req}); end
    checks++; if ({m3(), b3.stallM, b3.mem_req, dbg3} !== 13'h0000) begin errors++; $display("FAIL reset_dut3 got=%h exp=0000", {m3(), b3.stallM, b3.mem_req, dbg3}); end
    #5 rst = 1'b1;
  endtask

  task automatic test_non_mem();
    set_in(1'b1, 1'b0, 3'b001, 2'b00, 2'b00, 3'b010);
    tick();
    checks++; if (m2() !== 10'b001_00_00_010) begin errors++; $display("FAIL nonmem_m got=%b exp=%b", m2(), 10'b001_00_00_010); end
    checks++; if ({b2.stallM, b2.mem_req} !== 2'b00) begin errors++; $display("FAIL nonmem_stall_req got=%b exp=00", {b2.stallM, b2.mem_req}); end
    checks++; if ({b3.stallM, b3.mem_req} !== 2'b00) begin errors++; $display("FAIL nonmem_dut3 got=%b exp=00", {b3.stallM, b3.mem_req}); end
  endtask

  task automatic test_load_lat3();
    idle_cycles(2);
    set_in(1'b1, 1'b0, 3'b001, 2'b01, 2'b00, 3'b100);
    tick();
    checks++; if ({b3.mem_req, b3.stallM} !== 2'b11) begin errors++; $display("FAIL load3_e0 got=%b exp=11", {b3.mem_req, b3.stallM}); end
    checks++; if (m3() !== 10'b001_01_00_100) begin errors++; $display("FAIL load3_m0 got=%b exp=%b", m3(), 10'b001_01_00_100); end
    checks++; if ({b1.mem_req, b1.stallM} !== 2'b10) begin errors++; $display("FAIL load1_e0 got=%b exp=10", {b1.mem_req, b1.stallM}); end
    set_in(1'b1, 1'b0, 3'b111, 2'b00, 2'b00, 3'b000);
    tick();
    checks++; if ({b3.mem_req, b3.stallM} !== 2'b01) begin errors++; $display("FAIL load3_e1 got=%b exp=01", {b3.mem_req, b3.stallM}); end
    checks++; if (m3() !== 10'b001_01_00_100) begin errors++; $display("FAIL load3_m1 got=%b exp=%b", m3(), 10'b001_01_00_100); end
    checks++; if ({m1(), b1.mem_req, b1.stallM} !== {10'b111_00_00_000, 2'b00}) begin errors++; $display("FAIL load1_e1 got=%b exp=%b", {m1(), b1.mem_req, b1.stallM}, {10'b111_00_00_000, 2'b00}); end
    tick();
    checks++; if ({b3.mem_req, b3.stallM, dbg3} !== 3'b000) begin errors++; $display("FAIL load3_e2 got=%b exp=000", {b3.mem_req, b3.stallM, dbg3}); end
    checks++; if (m3() !== 10'b001_01_00_100) begin errors++; $display("FAIL load3_m2 got=%b exp=%b", m3(), 10'b001_01_00_100); end
    tick();
    checks++; if (m3() !== 10'b111_00_00_000) begin errors++; $display("FAIL load3_m3 got=%b exp=%b", m3(), 10'b111_00_00_000); end
  endtask

  task automatic test_flush();
    idle_cycles(3);
    set_in(1'b1, 1'b0, 3'b011, 2'b10, 2'b00, 3'b101);
    tick();
    checks++; if (m2() !== 10'b011_10_00_101) begin errors++; $display("FAIL flush_pre got=%b exp=%b", m2(), 10'b011_10_00_101); end
    set_in(1'b1, 1'b1, 3'b001, 2'b00, 2'b10, 3'b111);
    tick();
    checks++; if ({m2(), b2.mem_req, b2.stallM} !== 12'h000) begin errors++; $display("FAIL flush_bubble got=%b exp=0", {m2(), b2.mem_req, b2.stallM}); end
  endtask

  task automatic test_access_ignore();
    idle_cycles(3);
    set_in(1'b1, 1'b0, 3'b010, 2'b00, 2'b01, 3'b001);
    tick();
    checks++; if ({b3.mem_req, b3.stallM} !== 2'b11) begin errors++; $display("FAIL ign_e0 got=%b exp=11", {b3.mem_req, b3.stallM}); end
    set_in(1'b0, 1'b1, 3'b111, 2'b11, 2'b11, 3'b111);
    tick();
    checks++; if ({m3(), b3.stallM} !== {10'b010_00_01_001, 1'b1}) begin errors++; $display("FAIL ign_e1 got=%b exp=%b", {m3(), b3.stallM}, {10'b010_00_01_001, 1'b1}); end
    set_in(1'b1, 1'b1, 3'b111, 2'b11, 2'b11, 3'b111);
    tick();
    checks++; if ({m3(), b3.stallM, b3.mem_req} !== {10'b010_00_01_001, 2'b00}) begin errors++; $display("FAIL ign_e2 got=%b exp=%b", {m3(), b3.stallM, b3.mem_req}, {10'b010_00_01_001, 2'b00}); end
  endtask

  task automatic test_back_to_back();
    idle_cycles(3);
    set_in(1'b1, 1'b0, 3'b000, 2'b00, 2'b11, 3'b010);
    tick();
    checks++; if ({b2.mem_req, b2.stallM, b2.MemWriteM} !== 4'b1111) begin errors++; $display("FAIL b2b_store got=%b exp=1111", {b2.mem_req, b2.stallM, b2.MemWriteM}); end
    set_in(1'b1, 1'b0, 3'b001, 2'b01, 2'b00, 3'b100);
    tick();
    checks++; if ({b2.mem_req, b2.stallM, m2()} !== {2'b00, 10'b000_00_11_010}) begin errors++; $display("FAIL b2b_gap got=%b exp=%b", {b2.mem_req, b2.stallM, m2()}, {2'b00, 10'b000_00_11_010}); end
    tick();
    checks++; if ({b2.mem_req, b2.stallM, m2()} !== {2'b11, 10'b001_01_00_100}) begin errors++; $display("FAIL b2b_load got=%b exp=%b", {b2.mem_req, b2.stallM, m2()}, {2'b11, 10'b001_01_00_100}); end
    set_in(1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 3'b000);
    tick();
    checks++; if ({b2.mem_req, b2.stallM} !== 2'b00) begin errors++; $display("FAIL b2b_end got=%b exp=00", {b2.mem_req, b2.stallM}); end
  endtask

  task automatic test_async_reset();
    idle_cycles(3);
    set_in(1'b1, 1'b0, 3'b101, 2'b01, 2'b00, 3'b011);
    tick();
    checks++; if (b3.stallM !== 1'b1) begin errors++; $display("FAIL arst_pre got=%b exp=1", b3.stallM); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({m3(), b3.stallM, b3.mem_req, dbg3} !== 13'h0000) begin errors++; $display("FAIL arst_now got=%b exp=0", {m3(), b3.stallM, b3.mem_req, dbg3}); end
    set_in(1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 3'b000);
    #10 rst = 1'b1;
    tick();
    checks++; if ({b3.stallM, b3.mem_req, dbg3} !== 3'b000) begin errors++; $display("FAIL arst_rel1 got=%b exp=000", {b3.stallM, b3.mem_req, dbg3}); end
    tick();
    checks++; if ({b3.stallM, b3.mem_req} !== 2'b00) begin errors++; $display("FAIL arst_rel2 got=%b exp=00", {b3.stallM, b3.mem_req}); end
    set_in(1'b1, 1'b0, 3'b110, 2'b00, 2'b00, 3'b001);
    tick();
    checks++; if (m3() !== 10'b110_00_00_001) begin errors++; $display("FAIL arst_resume got=%b exp=%b", m3(), 10'b110_00_00_001); end
  endtask

  // sequence and report
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_non_mem();
    test_load_lat3();
    test_flush();
    test_access_ignore();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exe_mem_control.md
EXE_MEM_CONTROL -- requirements
Module: exe_mem_control

Parameters
REQ-001 SHALL have parameter MEM_LATENCY, default 2, meaning data-memory access length in cycles (legal range 1..15).
REQ-002 SHALL have parameter CNT_WIDTH, default 4, meaning the width of the access counter (must satisfy 2^CNT_WIDTH > MEM_LATENCY).

Interface
REQ-003 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have en  input  1  capture enable from the hazard unit.
REQ-006 SHALL have flush  input  1  inserts a bubble in place of the Execute-stage values.
REQ-007 SHALL have RegWriteE  input  3  Execute-stage register-write control.
REQ-008 SHALL have ResultSrcE  input  2  Execute-stage result select; 2'b01 means load.
REQ-009 SHALL have MemWriteE  input  2  Execute-stage store size; nonzero means store.
REQ-010 SHALL have funct3E  input  3  Execute-stage funct3.
REQ-011 SHALL have RegWriteM, ResultSrcM, MemWriteM, funct3M  output  3/2/2/3  Memory-stage copies of the Execute-stage inputs.
REQ-012 SHALL have stallM  output  1  stall request to the upstream stages while an access is in progress.
REQ-013 SHALL have mem_req  output  1  single-cycle strobe that starts a data-memory access.

Function
REQ-014 SHALL treat a captured instruction as a memory op when MemWriteE!=0 or ResultSrcE==2'b01.
REQ-015 SHALL implement a two-state FSM with states IDLE and ACCESS.
REQ-016 SHALL capture inputs into the M outputs at a rising edge only when state==IDLE and en==1.
REQ-017 SHALL capture all-zero values (a bubble) instead of the inputs when flush==1 and a capture occurs.
REQ-018 SHALL keep all M outputs unchanged when no capture occurs.
REQ-019 SHALL register mem_req=1 for exactly the one cycle after capturing a non-bubble memory op, and 0 at all other times.
REQ-020 SHALL, on capturing a memory op with MEM_LATENCY>1, go to ACCESS and load the counter with MEM_LATENCY-1.
REQ-021 SHALL, with MEM_LATENCY==1, stay in IDLE and never assert stallM.
REQ-022 SHALL, in ACCESS, decrement the counter on each edge and return to IDLE on the edge where the counter equals 1.
REQ-023 SHALL drive stallM combinationally as state==ACCESS, giving exactly MEM_LATENCY-1 stall cycles per memory op.
REQ-024 SHALL ignore en and flush while in ACCESS, so an in-flight access is never aborted or overwritten.
REQ-025 SHALL allow a new capture on the same edge at which ACCESS returns to IDLE only if state was IDLE before that edge; a back-to-back memory op is therefore captured on the first edge after stallM drops.
REQ-026 SHALL never let the counter underflow or wrap; the counter holds 0 while in IDLE.

Reset
REQ-027 SHALL, whenever rst==0, immediately set state=IDLE, counter=0, and all M outputs, mem_req and stallM to 0, regardless of clk.
REQ-028 SHALL, if reset is asserted mid-access, abandon that access completely; after reset deasserts the block starts in IDLE with no pending request.
REQ-029 SHALL resume normal capture on the first rising edge after rst returns to 1.

Verification
REQ-030 SHALL cover a non-memory op: RegWriteE=3'b001, ResultSrcE=0, MemWriteE=0, en=1 -> next cycle RegWriteM=3'b001, stallM=0, mem_req=0.
REQ-031 SHALL cover a load with MEM_LATENCY=3: ResultSrcE=2'b01, en=1 -> mem_req=1 for 1 cycle, stallM=1 for 2 cycles, M outputs held for 3 cycles.
REQ-032 SHALL cover flush: flush=1, en=1, MemWriteE=2'b10 -> all M outputs 0, mem_req=0, stallM=0.
REQ-033 SHALL cover en=0 and flush=1 during ACCESS -> M outputs and counter sequence unchanged, and stallM drops on schedule.
REQ-034 SHALL cover a store followed by a load back-to-back, MEM_LATENCY=2 -> store stalls 1 cycle, load captured the next edge, then mem_req and stallM repeat.
REQ-035 SHALL cover rst=0 asserted asynchronously mid-ACCESS -> stallM=0 and outputs=0 immediately, with no mem_req after release.
